demod_segment_scheduler: RTL and testbench

- Sequences one shared demodulation segment datapath (threshold/compare unit) across NUM_SEG segment slots.
- Per frame: accepts one Q16.16 sample per segment and drives the datapath with that segment's ref/ref_m pair. Collects each result into a result bank and signals frame completion.
- Sits between the input sample stream and the time-multiplexed datapath, replacing per-segment datapath instances.

---
 rtl/demod_pkg.sv | 7 +
 rtl/demod_ref_rom.sv | 15 +
 rtl/demod_segment_scheduler.sv | 108 ++++++++++
 tb/tb_demod_segment_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/demod_pkg.sv
// demod_pkg: Q16.16 constants, scheduler FSM states and default slot count.
package demod_pkg;
   localparam logic [31:0] Q_ONE       = 32'h0001_0000;
   localparam logic [31:0] Q_MINUS_ONE = 32'hFFFF_0000;
   localparam int          NUM_SEG_DEF = 10;
   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/demod_ref_rom.sv
// demod_ref_rom: segment index to {ref, ref_m}; even slots get +1/-1, odd slots -1/+1.
module demod_ref_rom
   import demod_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [3:0]    i_idx,
   output logic [DW-1:0] o_ref,
   output logic [DW-1:0] o_ref_m
);
   logic w_odd;
   assign w_odd   = (i_idx % 4'd2) != 4'd0;
   assign o_ref   = w_odd ? DW'(Q_MINUS_ONE) : DW'(Q_ONE);
   assign o_ref_m = w_odd ? DW'(Q_ONE) : DW'(Q_MINUS_ONE);
endmodule

// File: rtl/demod_segment_scheduler.sv
// demod_segment_scheduler: time-multiplexes one demod datapath over NUM_SEG slots per frame.
// Optional WAIT watchdog with sticky o_err under macro DEMOD_SCHED_TIMEOUT_EN.
module demod_segment_scheduler
   import demod_pkg::*;
#(
   parameter int NUM_SEG = NUM_SEG_DEF,
   parameter int DW = 32
`ifdef DEMOD_SCHED_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 64
`endif
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [DW-1:0]         i_in_sample,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   output logic                  o_dp_start,
   output logic [3:0]            o_dp_sel,
   output logic [DW-1:0]         o_dp_sample,
   output logic [DW-1:0]         o_dp_ref,
   output logic [DW-1:0]         o_dp_ref_m,
   input  logic                  i_dp_done,
   input  logic [DW-1:0]         i_dp_result,
   output logic [NUM_SEG*DW-1:0] o_seg_results,
   output logic                  o_valid,
   output logic                  o_busy,
   output logic                  o_err
);
   state_t                r_state, w_next;
   logic [3:0]            r_seg_idx;
   logic [DW-1:0]         r_dp_sample;
   logic [NUM_SEG*DW-1:0] r_results;
   logic                  w_hs, w_adv, w_last, w_tmo;

   assign w_hs   = (r_state == LOAD) && i_in_valid;
   assign w_last = r_seg_idx == 4'(NUM_SEG - 1);
   assign w_adv  = (r_state == WAIT) && (i_dp_done || w_tmo);

`ifdef DEMOD_SCHED_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] r_wcnt;
   logic          r_err;
   // counter sits at 0 outside WAIT, so it is clear on every WAIT entry
   assign w_tmo = (r_state == WAIT) && !i_dp_done && (r_wcnt == CW'(TIMEOUT_CYC - 1));
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wcnt <= '0;
         r_err  <= 1'b0;
      end else begin
         r_wcnt <= (r_state == WAIT) ? r_wcnt + CW'(1) : '0;
         r_err  <= r_err | w_tmo;
      end
   end
   assign o_err = r_err;
`else
   assign w_tmo = 1'b0;
   assign o_err = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = i_start ? LOAD : IDLE;
         LOAD:    w_next = i_in_valid ? ISSUE : LOAD;
         ISSUE:   w_next = WAIT;
         WAIT:    w_next = w_adv ? (w_last ? DONE : LOAD) : WAIT;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      o_in_ready = r_state == LOAD;
      o_dp_start = r_state == ISSUE;
      o_valid    = r_state == DONE;
      o_busy     = (r_state == LOAD) || (r_state == ISSUE) || (r_state == WAIT);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_seg_idx   <= '0;
         r_dp_sample <= '0;
         r_results   <= '0;
      end else begin
         if (w_hs) r_dp_sample <= i_in_sample;
         if (w_adv) r_results[int'(r_seg_idx)*DW +: DW] <= i_dp_done ? i_dp_result : '0;
         if (r_state == DONE) r_seg_idx <= '0;
         else if (w_adv && !w_last) r_seg_idx <= r_seg_idx + 4'd1;
      end
   end

   assign o_dp_sel      = r_seg_idx;
   assign o_dp_sample   = r_dp_sample;
   assign o_seg_results = r_results;

   demod_ref_rom #(.DW(DW)) u_rom (
      .i_idx  (r_seg_idx),
      .o_ref  (o_dp_ref),
      .o_ref_m(o_dp_ref_m)
   );
endmodule

// File: tb/tb_demod_segment_scheduler.sv
// tb_demod_segment_scheduler: random and directed frames checked against a protocol-level model.
module tb_demod_segment_scheduler;
   import demod_pkg::*;
   localparam int NS = 10;
`ifdef DEMOD_SCHED_TIMEOUT_EN
   localparam int TO = 8;
   localparam bit TMO_EN = 1'b1;
`else
   localparam int TO = 64;
   localparam bit TMO_EN = 1'b0;
`endif

   logic clk = 0, rst_n = 0, start_main = 0, start_noise = 0, in_valid = 0;
   logic resp_done = 0, stray_done = 0;
   logic [31:0] in_sample = 0, dp_result = 0;
   logic start, dp_done, o_in_ready, o_dp_start, o_valid, o_busy, o_err;
   logic [3:0] o_dp_sel;
   logic [31:0] o_dp_sample, o_dp_ref, o_dp_ref_m;
   logic [NS*32-1:0] o_seg_results;
   assign start   = start_main | start_noise;
   assign dp_done = resp_done | stray_done;

   demod_segment_scheduler #(.NUM_SEG(NS), .DW(32)
`ifdef DEMOD_SCHED_TIMEOUT_EN
      , .TIMEOUT_CYC(TO)
`endif
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_in_sample(in_sample), .i_in_valid(in_valid),
      .o_in_ready(o_in_ready), .o_dp_start(o_dp_start), .o_dp_sel(o_dp_sel), .o_dp_sample(o_dp_sample),
      .o_dp_ref(o_dp_ref), .o_dp_ref_m(o_dp_ref_m), .i_dp_done(dp_done), .i_dp_result(dp_result),
      .o_seg_results(o_seg_results), .o_valid(o_valid), .o_busy(o_busy), .o_err(o_err)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0, cyc = 0;
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // reference model: expected result bank plus handshake-level protocol state
   logic [31:0] bank[NS], last_acc = 0, rec_ref[16], rec_refm[16];
   int exp_idx = 0, wait_cnt = 0, first_ready_cyc = -1, valid_cyc = -1, valid_count = 0;
   bit exp_busy = 0, exp_vld = 0, waiting = 0, hs_prev = 0, exp_err = 0;
   initial for (int k = 0; k < NS; k++) bank[k] = 0;

   always @(negedge clk) begin
      bit idle, tmo, acc, nv;
      if (!rst_n) begin
         for (int k = 0; k < NS; k++) bank[k] = 0;
         exp_idx = 0; exp_busy = 0; exp_vld = 0; waiting = 0; hs_prev = 0; exp_err = 0; wait_cnt = 0;
         chk("dp_sample_rst", o_dp_sample, 0);
      end
      chk("busy", o_busy, exp_busy);
      chk("valid", o_valid, exp_vld);
      chk("in_ready", o_in_ready, exp_busy && !waiting && !hs_prev);
      chk("dp_start", o_dp_start, hs_prev);
      chk("err", o_err, exp_err);
      for (int k = 0; k < NS; k++) chk($sformatf("slot%0d", k), o_seg_results[k*32 +: 32], bank[k]);
      if (hs_prev || waiting) begin
         chk("dp_sel", o_dp_sel, exp_idx);
         chk("dp_sample", o_dp_sample, last_acc);
         chk("dp_ref", o_dp_ref, (exp_idx % 2 == 0) ? 32'h0001_0000 : 32'hFFFF_0000);
         chk("dp_ref_m", o_dp_ref_m, (exp_idx % 2 == 0) ? 32'hFFFF_0000 : 32'h0001_0000);
      end
      if (o_valid) begin valid_cyc = cyc; valid_count++; end
      if (o_in_ready && first_ready_cyc < 0) first_ready_cyc = cyc;
      if (o_dp_start) begin rec_ref[o_dp_sel] = o_dp_ref; rec_refm[o_dp_sel] = o_dp_ref_m; end
      if (rst_n) begin
         idle = !exp_busy && !exp_vld;
         acc  = exp_busy && !waiting && !hs_prev && in_valid;
         nv   = 0;
         if (waiting) begin
            tmo = TMO_EN && (wait_cnt == TO - 1);
            if (dp_done || tmo) begin
               bank[exp_idx] = dp_done ? dp_result : 32'd0;
               if (!dp_done) exp_err = 1;
               waiting = 0;
               if (exp_idx == NS - 1) begin nv = 1; exp_busy = 0; exp_idx = 0; end
               else exp_idx++;
            end else wait_cnt++;
         end
         if (hs_prev) begin waiting = 1; wait_cnt = 0; end
         if (acc) last_acc = in_sample;
         if (idle && start) exp_busy = 1;
         hs_prev = acc;
         exp_vld = nv;
      end
   end

   // stimulus drivers: sample source, datapath responder, noise injectors
   logic [31:0] smp[NS], cap = 0;
   int mode = 0, dmax = 1, ptr = 0, cd = 0, rdy_cnt = 0, suppress = -1, exact_sel = -1;
   bit noise = 0, last_hs = 0;
   always @(negedge clk) last_hs = o_in_ready && in_valid;
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin ptr = 0; cd = 0; end
      else if (!o_busy) ptr = 0;
      else if (last_hs) ptr++;
      rdy_cnt   = o_in_ready ? rdy_cnt + 1 : 0;
      in_valid  = (mode == 0) ? 1'b1 : (mode == 1) ? (rdy_cnt > 5) : ($urandom % 3 != 0);
      in_sample = smp[ptr % NS];
      resp_done = 0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin resp_done = 1; dp_result = cap * 2; end
      end
      if (o_dp_start && rst_n) begin
         cap = o_dp_sample;
         cd  = (int'(o_dp_sel) == exact_sel) ? TO : (int'(o_dp_sel) == suppress) ? 0 : int'($urandom_range(1, dmax));
      end
      stray_done  = noise && (o_in_ready || !o_busy) && ($urandom % 2 == 0);
      start_noise = noise && (o_busy || o_valid) && ($urandom % 4 == 0);
   end

   task automatic frame();
      int n = 0;
      first_ready_cyc = -1;
      @(posedge clk); #1 start_main = 1;
      @(posedge clk); #1 start_main = 0;
      while (!o_valid && n < 3000) begin @(negedge clk); n++; end
      chk("frame_completes", n < 3000, 1);
      @(posedge clk);
   endtask

   task automatic chk_slots();
      for (int k = 0; k < NS; k++) chk($sformatf("lit_slot%0d", k), o_seg_results[k*32 +: 32], 2 * (k + 1));
   endtask

   initial begin
      int vc, n;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      for (int k = 0; k < NS; k++) smp[k] = k + 1;
      // back-to-back samples, immediate dp_done
      mode = 0; dmax = 1;
      frame();
      chk_slots();
      chk("latency", valid_cyc - first_ready_cyc, 30);
      chk("valid_count1", valid_count, 1);
      chk("ref_k0", rec_ref[0], 32'h0001_0000);
      chk("refm_k0", rec_refm[0], 32'hFFFF_0000);
      chk("ref_k1", rec_ref[1], 32'hFFFF_0000);
      chk("refm_k1", rec_refm[1], 32'h0001_0000);
      // gaps on in_valid and slower datapath
      mode = 1; dmax = 3;
      frame();
      chk_slots();
      // spurious start and dp_done pulses
      mode = 0; dmax = 2; noise = 1; vc = valid_count;
      frame();
      noise = 0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("one_valid", valid_count, vc + 1);
      chk("no_restart", o_busy, 0);
      chk_slots();
      // reset during segment 4 WAIT
      mode = 0; dmax = 1; vc = valid_count;
      @(posedge clk); #1 start_main = 1;
      @(posedge clk); #1 start_main = 0;
      n = 0;
      while (!(o_dp_start && o_dp_sel == 4) && n < 500) begin @(negedge clk); n++; end
      chk("reach_seg4", n < 500, 1);
      @(posedge clk); #2 rst_n = 0;
      #1;
      chk("rst_busy", o_busy, 0);
      chk("rst_ready", o_in_ready, 0);
      chk("rst_dp_start", o_dp_start, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_sel", o_dp_sel, 0);
      chk("rst_sample", o_dp_sample, 0);
      chk("rst_results", o_seg_results == '0, 1);
      @(posedge clk); #1 rst_n = 1;
      chk("no_valid_abandoned", valid_count, vc);
      frame();
      chk_slots();
      chk("valid_after_rst", valid_count, vc + 1);
      // randomized frames
      for (int f = 0; f < 6; f++) begin
         for (int k = 0; k < NS; k++) smp[k] = $urandom;
         mode = 2; dmax = 4;
         frame();
      end
`ifdef DEMOD_SCHED_TIMEOUT_EN
      for (int k = 0; k < NS; k++) smp[k] = k + 1;
      mode = 0; dmax = 1; suppress = 2;
      frame();
      chk("tmo_slot2", o_seg_results[2*32 +: 32], 0);
      chk("tmo_slot3", o_seg_results[3*32 +: 32], 8);
      chk("tmo_err", o_err, 1);
      suppress = -1; exact_sel = 3;
      frame();
      chk("tie_slot3", o_seg_results[3*32 +: 32], 8);
      chk("tie_slot2", o_seg_results[2*32 +: 32], 6);
      chk("err_sticky", o_err, 1);
      exact_sel = -1;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
